// File: rtl/puf_readout_sequencer_if.sv
// Signal bundle for the PUF readout sequencer: sweep control, the PUF core
// START/address/response lines and the downstream response handshake.
// "slave" is the sequencer's view, "master" is the surrounding logic's view.
interface puf_readout_sequencer_if #(
  parameter int ADDR_W = 4
) ();
  logic              req;
  logic              abort;
  logic              puf_start;
  logic [ADDR_W-1:0] puf_addr;
  logic [7:0]        puf_out;
  logic [7:0]        rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_unstable;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              busy;
  logic              done;

  modport master (
    output req, abort, puf_out, rsp_ready,
    input  puf_start, puf_addr, rsp_data, rsp_addr, rsp_unstable,
           rsp_valid, busy, done
  );

  modport slave (
    input  req, abort, puf_out, rsp_ready,
    output puf_start, puf_addr, rsp_data, rsp_addr, rsp_unstable,
           rsp_valid, busy, done
  );
endinterface

// File: rtl/puf_readout_sequencer.sv
// PUF readout sequencer: sweeps every challenge address, evaluates each one
// REPEAT times, majority-votes every response bit and hands the voted byte
// plus an instability flag to a valid/ready consumer.
module puf_readout_sequencer #(
  parameter int ADDR_W = 4,
  parameter int SETTLE = 8,
  parameter int REPEAT = 3
) (
  input logic                     clk,
  input logic                     rst_n,
  puf_readout_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_OUT    = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST   = {ADDR_W{1'b1}};
  localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [2:0]        REP_LAST    = 3'(REPEAT - 1);
  localparam logic [2:0]        REP_FULL    = 3'(REPEAT);
  localparam logic [2:0]        REP_HALF    = 3'(REPEAT / 2);

  // Per-bit majority: a bit is 1 when more than half of the evaluations saw 1.
  function automatic logic [7:0] vote(input logic [7:0][2:0] ones);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      v[i] = (ones[i] > REP_HALF);
    end
    return v;
  endfunction

  // Any bit whose ones-count is neither all-zero nor all-one flipped at least once.
  function automatic logic disagree(input logic [7:0][2:0] ones);
    logic u;
    u = 1'b0;
    for (int i = 0; i < 8; i++) begin
      u = u | ((ones[i] != 3'd0) && (ones[i] != REP_FULL));
    end
    return u;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          rep_q, rep_d;
  logic [7:0]          timer_q, timer_d;
  logic [7:0][2:0]     ones_q, ones_d;
  logic                puf_start_q, puf_start_d;
  logic [ADDR_W-1:0]   puf_addr_q, puf_addr_d;
  logic [7:0]          rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;
  logic                rsp_unstable_q, rsp_unstable_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state and registered-output decode; abort overrides everything.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    rep_d          = rep_q;
    timer_d        = timer_q;
    ones_d         = ones_q;
    rsp_data_d     = rsp_data_q;
    rsp_addr_d     = rsp_addr_q;
    rsp_unstable_d = rsp_unstable_q;
    rsp_valid_d    = rsp_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req && !bus.abort) begin
          addr_d  = {ADDR_W{1'b0}};
          rep_d   = 3'd0;
          ones_d  = '0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        timer_d = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + 8'd1;
        if (timer_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_SAMPLE: begin
        for (int i = 0; i < 8; i++) begin
          ones_d[i] = ones_q[i] + {2'b00, bus.puf_out[i]};
        end
        if (rep_q == REP_LAST) begin
          rsp_data_d     = vote(ones_d);
          rsp_unstable_d = disagree(ones_d);
          rsp_addr_d     = addr_q;
          rsp_valid_d    = 1'b1;
          state_d        = ST_OUT;
        end else begin
          rep_d   = rep_q + 3'd1;
          state_d = ST_START;
        end
      end
      ST_OUT: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (addr_q == ADDR_LAST) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            rep_d   = 3'd0;
            ones_d  = '0;
            state_d = ST_START;
          end
        end else begin
          state_d = ST_OUT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort in IDLE only clears already-idle counters, so it is invisible there.
    if (bus.abort) begin
      state_d     = ST_IDLE;
      addr_d      = {ADDR_W{1'b0}};
      rep_d       = 3'd0;
      timer_d     = 8'd0;
      ones_d      = '0;
      rsp_valid_d = 1'b0;
    end else begin
      state_d = state_d;
    end

    puf_start_d = (state_d == ST_START);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    if (state_d == ST_IDLE) begin
      puf_addr_d = {ADDR_W{1'b0}};
    end else if (state_d == ST_START) begin
      puf_addr_d = addr_d;
    end else begin
      puf_addr_d = puf_addr_q;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      addr_q         <= {ADDR_W{1'b0}};
      rep_q          <= 3'd0;
      timer_q        <= 8'd0;
      ones_q         <= '0;
      puf_start_q    <= 1'b0;
      puf_addr_q     <= {ADDR_W{1'b0}};
      rsp_data_q     <= 8'h00;
      rsp_addr_q     <= {ADDR_W{1'b0}};
      rsp_unstable_q <= 1'b0;
      rsp_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      rep_q          <= rep_d;
      timer_q        <= timer_d;
      ones_q         <= ones_d;
      puf_start_q    <= puf_start_d;
      puf_addr_q     <= puf_addr_d;
      rsp_data_q     <= rsp_data_d;
      rsp_addr_q     <= rsp_addr_d;
      rsp_unstable_q <= rsp_unstable_d;
      rsp_valid_q    <= rsp_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign bus.puf_start    = puf_start_q;
  assign bus.puf_addr     = puf_addr_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_addr     = rsp_addr_q;
  assign bus.rsp_unstable = rsp_unstable_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_puf_readout_sequencer.sv
// Bench for puf_readout_sequencer: a PUF response table drives puf_out per
// evaluation, a negedge monitor collects handshakes, and the expected vote
// is recomputed from the table by counting ones per bit.
module tb_puf_readout_sequencer;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
    logic       u;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  puf_readout_sequencer_if #(.ADDR_W(4)) b1 ();
  puf_readout_sequencer_if #(.ADDR_W(2)) b2 ();

  puf_readout_sequencer #(.ADDR_W(4), .SETTLE(8), .REPEAT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  puf_readout_sequencer #(.ADDR_W(2), .SETTLE(1), .REPEAT(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PUF response tables: tab[addr][evaluation] for dut1, tab2[addr] for dut2.
  logic [7:0] tab [16][3];
  logic [7:0] tab2 [4];
  assign b2.puf_out = tab2[b2.puf_addr];

  // Monitor state for dut1.
  int   ev_cnt [16];
  int   start_cnt = 0, start_in_out = 0, done_cnt = 0;
  int   done_cyc = 0, hs_cyc = 0, first_rise = 0;
  logic vprev = 1'b0;
  rec_t rec_q [$];

  // Drive puf_out per evaluation and collect handshakes, pulses and timing.
  always @(negedge clk) begin
    if (!b1.busy) begin
      for (int i = 0; i < 16; i++) ev_cnt[i] <= 0;
    end else if (b1.puf_start) begin
      if (ev_cnt[b1.puf_addr] < 3) b1.puf_out <= tab[b1.puf_addr][ev_cnt[b1.puf_addr]];
      ev_cnt[b1.puf_addr] <= ev_cnt[b1.puf_addr] + 1;
    end
    if (b1.puf_start) start_cnt <= start_cnt + 1;
    if (b1.puf_start && b1.rsp_valid) start_in_out <= start_in_out + 1;
    if (b1.rsp_valid && b1.rsp_ready && !b1.abort && rst_n) begin
      rec_q.push_back('{b1.rsp_addr, b1.rsp_data, b1.rsp_unstable});
      hs_cyc <= cyc + 1;
    end
    if (b1.done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (!b1.busy && b1.req) first_rise <= 0;
    else if (b1.rsp_valid && !vprev && first_rise == 0) first_rise <= cyc;
    vprev <= b1.rsp_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference vote: bit set when ones exceed half of 3 evaluations.
  function automatic logic [8:0] model(input int a);
    int ones;
    logic [7:0] d;
    logic u;
    d = 8'h00;
    u = 1'b0;
    for (int b = 0; b < 8; b++) begin
      ones = 0;
      for (int e = 0; e < 3; e++) ones += int'(tab[a][e][b]);
      d[b] = (2 * ones > 3);
      if (ones != 0 && ones != 3) u = 1'b1;
    end
    return {u, d};
  endfunction

  task automatic fill_random();
    logic [7:0] base, flip;
    for (int a = 0; a < 16; a++) begin
      base = 8'($urandom);
      for (int e = 0; e < 3; e++) begin
        flip = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
        tab[a][e] = base ^ flip;
      end
    end
  endtask

  task automatic check_sweep(input int n0, input string tag);
    rec_t r;
    logic [8:0] m;
    check({tag, "_count"}, 32'(rec_q.size() - n0), 32'd16);
    for (int i = 0; i < 16 && n0 + i < rec_q.size(); i++) begin
      r = rec_q[n0 + i];
      m = model(i);
      check({tag, "_addr"}, 32'(r.a), 32'(i));
      check({tag, "_data"}, 32'(r.d), 32'(m[7:0]));
      check({tag, "_unstable"}, 32'(r.u), 32'(m[8]));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_puf_start"}, 32'(b1.puf_start), 32'd0);
    check({tag, "_puf_addr"}, 32'(b1.puf_addr), 32'd0);
    check({tag, "_rsp_data"}, 32'(b1.rsp_data), 32'd0);
    check({tag, "_rsp_addr"}, 32'(b1.rsp_addr), 32'd0);
    check({tag, "_rsp_unstable"}, 32'(b1.rsp_unstable), 32'd0);
    check({tag, "_rsp_valid"}, 32'(b1.rsp_valid), 32'd0);
    check({tag, "_busy"}, 32'(b1.busy), 32'd0);
    check({tag, "_done"}, 32'(b1.done), 32'd0);
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_req();
    @(posedge clk); #1; b1.req = 1'b1;
    @(posedge clk); #1; b1.req = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int n0, d0, s0, s1, req_cyc, n;
    rst_n = 1'b0;
    b1.req = 1'b0; b1.abort = 1'b0; b1.rsp_ready = 1'b0;
    b2.req = 1'b0; b2.abort = 1'b0; b2.rsp_ready = 1'b0;
    for (int a = 0; a < 4; a++) tab2[a] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // Constant A5 PUF, ready always high.
    for (int a = 0; a < 16; a++) for (int e = 0; e < 3; e++) tab[a][e] = 8'hA5;
    b1.rsp_ready = 1'b1;
    n0 = rec_q.size(); d0 = done_cnt; s0 = start_cnt;
    @(posedge clk); #1; b1.req = 1'b1; req_cyc = cyc + 1;
    @(posedge clk); #1; b1.req = 1'b0;
    wait_done(d0, 1500);
    check("a_done_once", 32'(done_cnt - d0), 32'd1);
    check("a_latency", 32'(first_rise), 32'(req_cyc + 30));
    check("a_start_pulses", 32'(start_cnt - s0), 32'd48);
    check("a_done_after_hs", 32'(done_cyc), 32'(hs_cyc));
    check_sweep(n0, "a");
    if (rec_q.size() >= n0 + 16) check("a_last_data", 32'(rec_q[n0 + 15].d), 32'hA5);

    // Random PUF with directed unstable addresses, stall at address 0.
    fill_random();
    tab[3][0] = 8'hA5; tab[3][1] = 8'hA4; tab[3][2] = 8'hA5;
    tab[4][0] = 8'hA4; tab[4][1] = 8'hA4; tab[4][2] = 8'hA5;
    b1.rsp_ready = 1'b0;
    n0 = rec_q.size(); d0 = done_cnt;
    pulse_req();
    n = 0;
    do begin samp(); n++; end while (!b1.rsp_valid && n < 200);
    check("b_valid_rise", 32'(b1.rsp_valid), 32'd1);
    s1 = start_cnt;
    for (int k = 0; k < 5; k++) begin
      samp();
      check("b_stall_valid", 32'(b1.rsp_valid), 32'd1);
      check("b_stall_addr", 32'(b1.rsp_addr), 32'd0);
      check("b_stall_data", 32'(b1.rsp_data), 32'(model(0) & 9'h0FF));
    end
    check("b_stall_no_start", 32'(start_cnt - s1), 32'd0);
    @(posedge clk); #1; b1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("b_next_start", 32'(b1.puf_start), 32'd1);
    check("b_next_addr", 32'(b1.puf_addr), 32'd1);
    check("b_valid_clear", 32'(b1.rsp_valid), 32'd0);
    wait_done(d0, 1500);
    check("b_done_once", 32'(done_cnt - d0), 32'd1);
    check_sweep(n0, "b");
    if (rec_q.size() >= n0 + 16) begin
      check("b_addr3_data", 32'(rec_q[n0 + 3].d), 32'hA5);
      check("b_addr3_unstable", 32'(rec_q[n0 + 3].u), 32'd1);
      check("b_addr4_data", 32'(rec_q[n0 + 4].d), 32'hA4);
      check("b_addr4_unstable", 32'(rec_q[n0 + 4].u), 32'd1);
    end

    // Abort during WAIT of address 7, then restart with a stray req mid-sweep.
    fill_random();
    d0 = done_cnt;
    pulse_req();
    n = 0;
    do begin samp(); n++; end while (!(b1.puf_start && b1.puf_addr == 4'd7) && n < 1000);
    check("c_reach_addr7", 32'(b1.puf_addr), 32'd7);
    samp(); samp();
    @(posedge clk); #1; b1.abort = 1'b1;
    @(posedge clk); #1; b1.abort = 1'b0;
    check("c_abort_busy", 32'(b1.busy), 32'd0);
    check("c_abort_start", 32'(b1.puf_start), 32'd0);
    check("c_abort_valid", 32'(b1.rsp_valid), 32'd0);
    check("c_abort_addr", 32'(b1.puf_addr), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("c_abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("c_abort_idle", 32'(b1.busy), 32'd0);
    n0 = rec_q.size();
    pulse_req();
    check("c_restart_start", 32'(b1.puf_start), 32'd1);
    check("c_restart_addr", 32'(b1.puf_addr), 32'd0);
    repeat (60) @(posedge clk);
    #1; b1.req = 1'b1;
    @(posedge clk); #1; b1.req = 1'b0;
    wait_done(d0, 1500);
    check("c_done_once", 32'(done_cnt - d0), 32'd1);
    check_sweep(n0, "c");
    repeat (5) @(posedge clk);
    #1;
    check("c_no_extra_sweep", 32'(b1.busy), 32'd0);
    check("start_never_in_out", 32'(start_in_out), 32'd0);

    // Reset asserted while address 9 waits in OUT.
    fill_random();
    d0 = done_cnt;
    pulse_req();
    n = 0;
    do begin samp(); n++; end while (!(b1.puf_start && b1.puf_addr == 4'd9) && n < 1000);
    @(posedge clk); #1; b1.rsp_ready = 1'b0;
    n = 0;
    do begin samp(); n++; end while (!b1.rsp_valid && n < 200);
    check("d_out_addr", 32'(b1.rsp_addr), 32'd9);
    rst_n = 1'b0;
    #1;
    check_zero("d_async_rst");
    @(negedge clk); rst_n = 1'b1;
    b1.rsp_ready = 1'b1;
    repeat (5) samp();
    check("d_idle_busy", 32'(b1.busy), 32'd0);
    check("d_idle_start", 32'(b1.puf_start), 32'd0);
    check("d_no_done", 32'(done_cnt - d0), 32'd0);

    // REPEAT=1, SETTLE=1 instance: 3-cycle latency, never unstable.
    for (int a = 0; a < 4; a++) tab2[a] = 8'($urandom);
    b2.rsp_ready = 1'b1;
    @(posedge clk); #1; b2.req = 1'b1;
    @(posedge clk); #1; b2.req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("e_valid_early", 32'(b2.rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("e_valid_at_3", 32'(b2.rsp_valid), 32'd1);
    for (int a = 0; a < 4; a++) begin
      if (a != 0) begin
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!b2.rsp_valid && n < 20);
      end
      check("e_addr", 32'(b2.rsp_addr), 32'(a));
      check("e_data", 32'(b2.rsp_data), 32'(tab2[a]));
      check("e_unstable", 32'(b2.rsp_unstable), 32'd0);
    end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!b2.done && n < 20);
    check("e_done", 32'(b2.done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
